// File: rtl/id_ex_stage_if.sv
// Bundle between the ID side (forwarding selects, stage results, hazard inputs)
// and the ID/EX register outputs that feed EX and the forwarding unit.
interface id_ex_stage_if #(
  parameter int DATA_W = 16,
  parameter int CTRL_W = 8
);
  logic              id_valid;
  logic [3:0]        idreg1;
  logic [3:0]        idreg2;
  logic [DATA_W-1:0] id_rd1;
  logic [DATA_W-1:0] id_rd2;
  logic [DATA_W-1:0] id_r0;
  logic [3:0]        id_regDest;
  logic [1:0]        id_w;
  logic              id_memRead;
  logic [CTRL_W-1:0] id_ctrl;
  logic [1:0]        Op1Fwd;
  logic [1:0]        Op2Fwd;
  logic [1:0]        R0Fwd;
  logic [DATA_W-1:0] ex_result;
  logic [DATA_W-1:0] m_result;
  logic [DATA_W-1:0] wb_result;
  logic [DATA_W-1:0] ex_r0result;
  logic [DATA_W-1:0] m_r0result;
  logic [DATA_W-1:0] wb_r0result;
  logic              ex_busy;
  logic              flush;
  logic [1:0]        exW;
  logic [3:0]        exRegDest;
  logic              ex_valid;
  logic              ex_memRead;
  logic [DATA_W-1:0] ex_op1;
  logic [DATA_W-1:0] ex_op2;
  logic [DATA_W-1:0] ex_r0;
  logic [CTRL_W-1:0] ex_ctrl;
  logic              stall;
  logic [15:0]       stall_count;

  modport master (
    output id_valid, idreg1, idreg2, id_rd1, id_rd2, id_r0, id_regDest, id_w,
           id_memRead, id_ctrl, Op1Fwd, Op2Fwd, R0Fwd, ex_result, m_result,
           wb_result, ex_r0result, m_r0result, wb_r0result, ex_busy, flush,
    input  exW, exRegDest, ex_valid, ex_memRead, ex_op1, ex_op2, ex_r0,
           ex_ctrl, stall, stall_count
  );

  modport slave (
    input  id_valid, idreg1, idreg2, id_rd1, id_rd2, id_r0, id_regDest, id_w,
           id_memRead, id_ctrl, Op1Fwd, Op2Fwd, R0Fwd, ex_result, m_result,
           wb_result, ex_r0result, m_r0result, wb_r0result, ex_busy, flush,
    output exW, exRegDest, ex_valid, ex_memRead, ex_op1, ex_op2, ex_r0,
           ex_ctrl, stall, stall_count
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: resolves forwarded operands, inserts load-use bubbles,
// freezes on multi-cycle EX ops, flushes on taken branches, counts stall cycles.
module id_ex_stage #(
  parameter int DATA_W = 16,
  parameter int CTRL_W = 8
) (
  input  logic         clk,
  input  logic         rst,
  id_ex_stage_if.slave bus
);

  logic [DATA_W-1:0] op1_fwd, op2_fwd, r0_fwd;

  logic              ex_valid_q, ex_valid_d;
  logic [1:0]        exW_q, exW_d;
  logic [3:0]        exRegDest_q, exRegDest_d;
  logic              ex_memRead_q, ex_memRead_d;
  logic [DATA_W-1:0] ex_op1_q, ex_op1_d;
  logic [DATA_W-1:0] ex_op2_q, ex_op2_d;
  logic [DATA_W-1:0] ex_r0_q, ex_r0_d;
  logic [CTRL_W-1:0] ex_ctrl_q, ex_ctrl_d;
  logic [15:0]       stall_count_q, stall_count_d;

  logic lu;
  logic stall;

  always_comb begin
    op1_fwd = bus.id_rd1;
    case (bus.Op1Fwd)
      2'b01:   op1_fwd = bus.ex_result;
      2'b10:   op1_fwd = bus.m_result;
      2'b11:   op1_fwd = bus.wb_result;
      default: op1_fwd = bus.id_rd1;
    endcase
  end

  always_comb begin
    op2_fwd = bus.id_rd2;
    case (bus.Op2Fwd)
      2'b01:   op2_fwd = bus.ex_result;
      2'b10:   op2_fwd = bus.m_result;
      2'b11:   op2_fwd = bus.wb_result;
      default: op2_fwd = bus.id_rd2;
    endcase
  end

  always_comb begin
    r0_fwd = bus.id_r0;
    case (bus.R0Fwd)
      2'b01:   r0_fwd = bus.ex_r0result;
      2'b10:   r0_fwd = bus.m_r0result;
      2'b11:   r0_fwd = bus.wb_r0result;
      default: r0_fwd = bus.id_r0;
    endcase
  end

  // Hazard looks at the registered EX slot, i.e. the instruction ahead of ID.
  assign lu = bus.id_valid & ex_valid_q & ex_memRead_q & exW_q[0] &
              ((exRegDest_q == bus.idreg1) | (exRegDest_q == bus.idreg2));

  assign stall = (lu | bus.ex_busy) & ~bus.flush;

  always_comb begin
    ex_valid_d   = ex_valid_q;
    exW_d        = exW_q;
    exRegDest_d  = exRegDest_q;
    ex_memRead_d = ex_memRead_q;
    ex_op1_d     = ex_op1_q;
    ex_op2_d     = ex_op2_q;
    ex_r0_d      = ex_r0_q;
    ex_ctrl_d    = ex_ctrl_q;
    if (bus.flush || (!bus.ex_busy && (lu || !bus.id_valid))) begin
      ex_valid_d   = 1'b0;
      exW_d        = 2'b00;
      exRegDest_d  = 4'd0;
      ex_memRead_d = 1'b0;
      ex_op1_d     = '0;
      ex_op2_d     = '0;
      ex_r0_d      = '0;
      ex_ctrl_d    = '0;
    end else if (!bus.ex_busy) begin
      ex_valid_d   = 1'b1;
      exW_d        = bus.id_w;
      exRegDest_d  = bus.id_regDest;
      ex_memRead_d = bus.id_memRead;
      ex_op1_d     = op1_fwd;
      ex_op2_d     = op2_fwd;
      ex_r0_d      = r0_fwd;
      ex_ctrl_d    = bus.id_ctrl;
    end
  end

  assign stall_count_d = (stall && (stall_count_q != 16'hFFFF)) ?
                         stall_count_q + 16'd1 : stall_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q    <= 1'b0;
      exW_q         <= 2'b00;
      exRegDest_q   <= 4'd0;
      ex_memRead_q  <= 1'b0;
      ex_op1_q      <= '0;
      ex_op2_q      <= '0;
      ex_r0_q       <= '0;
      ex_ctrl_q     <= '0;
      stall_count_q <= 16'd0;
    end else begin
      ex_valid_q    <= ex_valid_d;
      exW_q         <= exW_d;
      exRegDest_q   <= exRegDest_d;
      ex_memRead_q  <= ex_memRead_d;
      ex_op1_q      <= ex_op1_d;
      ex_op2_q      <= ex_op2_d;
      ex_r0_q       <= ex_r0_d;
      ex_ctrl_q     <= ex_ctrl_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign bus.ex_valid    = ex_valid_q;
  assign bus.exW         = exW_q;
  assign bus.exRegDest   = exRegDest_q;
  assign bus.ex_memRead  = ex_memRead_q;
  assign bus.ex_op1      = ex_op1_q;
  assign bus.ex_op2      = ex_op2_q;
  assign bus.ex_r0       = ex_r0_q;
  assign bus.ex_ctrl     = ex_ctrl_q;
  assign bus.stall       = stall;
  assign bus.stall_count = stall_count_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: forwarding, load-use, busy hold,
// flush priority, stall counter saturation and reset mid-hold.
module tb_id_ex_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  id_ex_stage_if #(.DATA_W(16), .CTRL_W(8)) bus ();
  id_ex_stage #(.DATA_W(16), .CTRL_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int failures = 0;
  int exp_cnt = 0;
  logic [63:0] exp_q[$];
  logic [63:0] exp_v;

  // {ex_valid, exW, exRegDest, ex_memRead, ex_op1, ex_op2, ex_r0, ex_ctrl}
  wire [63:0] dut_vec = {bus.ex_valid, bus.exW, bus.exRegDest, bus.ex_memRead,
                         bus.ex_op1, bus.ex_op2, bus.ex_r0, bus.ex_ctrl};

  function automatic logic [63:0] pack(input logic v, input logic [1:0] w,
                                       input logic [3:0] rd, input logic mr,
                                       input logic [15:0] o1, input logic [15:0] o2,
                                       input logic [15:0] r0, input logic [7:0] ctrl);
    return {v, w, rd, mr, o1, o2, r0, ctrl};
  endfunction

  task automatic idle_inputs();
    bus.id_valid = 0; bus.idreg1 = 0; bus.idreg2 = 0;
    bus.id_rd1 = 0; bus.id_rd2 = 0; bus.id_r0 = 0;
    bus.id_regDest = 0; bus.id_w = 0; bus.id_memRead = 0; bus.id_ctrl = 0;
    bus.Op1Fwd = 0; bus.Op2Fwd = 0; bus.R0Fwd = 0;
    bus.ex_result = 0; bus.m_result = 0; bus.wb_result = 0;
    bus.ex_r0result = 0; bus.m_r0result = 0; bus.wb_r0result = 0;
    bus.ex_busy = 0; bus.flush = 0;
  endtask

  task automatic drive_id(input logic v, input logic [3:0] r1, input logic [3:0] r2,
                          input logic [3:0] rd, input logic [1:0] w, input logic mr,
                          input logic [7:0] ctrl, input logic [15:0] d1,
                          input logic [15:0] d2, input logic [15:0] d0);
    bus.id_valid = v; bus.idreg1 = r1; bus.idreg2 = r2; bus.id_regDest = rd;
    bus.id_w = w; bus.id_memRead = mr; bus.id_ctrl = ctrl;
    bus.id_rd1 = d1; bus.id_rd2 = d2; bus.id_r0 = d0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    checks++;
    if (dut_vec !== 64'd0) begin
      failures++; $display("FAIL reset_regs got=%h exp=%h", dut_vec, 64'd0);
    end
    checks++;
    if (bus.stall_count !== 16'd0) begin
      failures++; $display("FAIL reset_count got=%h exp=0000", bus.stall_count);
    end
    checks++;
    if (bus.stall !== 1'b0) begin
      failures++; $display("FAIL reset_stall got=%b exp=0", bus.stall);
    end
    rst = 1'b0;
    exp_cnt = 0;
  endtask

  task automatic test_fwd_mux();
    logic [15:0] op1_t[4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    logic [15:0] op2_t[4] = '{16'h0A0A, 16'h2222, 16'h3333, 16'h4444};
    logic [15:0] r0_t[4]  = '{16'h1234, 16'h5555, 16'h6666, 16'h7777};
    bus.ex_result = 16'h2222; bus.m_result = 16'h3333; bus.wb_result = 16'h4444;
    bus.ex_r0result = 16'h5555; bus.m_r0result = 16'h6666; bus.wb_r0result = 16'h7777;
    for (int i = 0; i < 4; i++) begin
      drive_id(1, 4'd5, 4'd6, 4'd7, 2'b01, 0, 8'h10 + 8'(i), 16'h1111, 16'h0A0A, 16'h1234);
      bus.Op1Fwd = 2'(i); bus.Op2Fwd = 2'(3 - i); bus.R0Fwd = 2'(i);
      exp_q.push_back(pack(1, 2'b01, 4'd7, 0, op1_t[i], op2_t[3-i], r0_t[i], 8'h10 + 8'(i)));
      #1;
      checks++;
      if (bus.stall !== 1'b0) begin
        failures++; $display("FAIL fwd_stall sel=%0d got=%b exp=0", i, bus.stall);
      end
      step();
      exp_v = exp_q.pop_front();
      checks++;
      if (dut_vec !== exp_v) begin
        failures++; $display("FAIL fwd_mux sel=%0d got=%h exp=%h", i, dut_vec, exp_v);
      end
    end
    bus.Op1Fwd = 0; bus.Op2Fwd = 0; bus.R0Fwd = 0;
  endtask

  task automatic test_load_use();
    drive_id(1, 4'd0, 4'd0, 4'd2, 2'b01, 1, 8'h21, 16'h0101, 16'h0202, 16'h0303);
    exp_q.push_back(pack(1, 2'b01, 4'd2, 1, 16'h0101, 16'h0202, 16'h0303, 8'h21));
    step();
    exp_v = exp_q.pop_front();
    checks++;
    if (dut_vec !== exp_v) begin
      failures++; $display("FAIL lu_load got=%h exp=%h", dut_vec, exp_v);
    end
    drive_id(1, 4'd4, 4'd2, 4'd9, 2'b01, 0, 8'h33, 16'h0404, 16'h0505, 16'h0606);
    #1;
    checks++;
    if (bus.stall !== 1'b1) begin
      failures++; $display("FAIL lu_stall got=%b exp=1", bus.stall);
    end
    exp_q.push_back(64'd0);
    exp_cnt++;
    step();
    exp_v = exp_q.pop_front();
    checks++;
    if (dut_vec !== exp_v) begin
      failures++; $display("FAIL lu_bubble got=%h exp=%h", dut_vec, exp_v);
    end
    bus.Op2Fwd = 2'b10; bus.m_result = 16'hABCD;
    #1;
    checks++;
    if (bus.stall !== 1'b0) begin
      failures++; $display("FAIL lu_release got=%b exp=0", bus.stall);
    end
    exp_q.push_back(pack(1, 2'b01, 4'd9, 0, 16'h0404, 16'hABCD, 16'h0606, 8'h33));
    step();
    exp_v = exp_q.pop_front();
    checks++;
    if (dut_vec !== exp_v) begin
      failures++; $display("FAIL lu_fwd got=%h exp=%h", dut_vec, exp_v);
    end
    checks++;
    if (bus.stall_count !== 16'(exp_cnt)) begin
      failures++; $display("FAIL lu_count got=%h exp=%h", bus.stall_count, 16'(exp_cnt));
    end
    bus.Op2Fwd = 0;
  endtask

  task automatic test_no_false_hazard();
    drive_id(1, 4'd0, 4'd0, 4'd3, 2'b01, 1, 8'h44, 16'h0010, 16'h0020, 16'h0030);
    exp_q.push_back(pack(1, 2'b01, 4'd3, 1, 16'h0010, 16'h0020, 16'h0030, 8'h44));
    step();
    exp_v = exp_q.pop_front();
    checks++;
    if (dut_vec !== exp_v) begin
      failures++; $display("FAIL nfh_load got=%h exp=%h", dut_vec, exp_v);
    end
    // Load to r3 in EX, ID reads r2: no match.
    drive_id(1, 4'd4, 4'd2, 4'd2, 2'b01, 0, 8'h55, 16'h0040, 16'h0050, 16'h0060);
    #1;
    checks++;
    if (bus.stall !== 1'b0) begin
      failures++; $display("FAIL nfh_dest_stall got=%b exp=0", bus.stall);
    end
    exp_q.push_back(pack(1, 2'b01, 4'd2, 0, 16'h0040, 16'h0050, 16'h0060, 8'h55));
    step();
    exp_v = exp_q.pop_front();
    checks++;
    if (dut_vec !== exp_v) begin
      failures++; $display("FAIL nfh_dest_latch got=%h exp=%h", dut_vec, exp_v);
    end
    // Non-load writing r2 in EX, ID reads r2: no match.
    drive_id(1, 4'd2, 4'd2, 4'd5, 2'b01, 0, 8'h66, 16'h0070, 16'h0080, 16'h0090);
    #1;
    checks++;
    if (bus.stall !== 1'b0) begin
      failures++; $display("FAIL nfh_mr_stall got=%b exp=0", bus.stall);
    end
    exp_q.push_back(pack(1, 2'b01, 4'd5, 0, 16'h0070, 16'h0080, 16'h0090, 8'h66));
    step();
    exp_v = exp_q.pop_front();
    checks++;
    if (dut_vec !== exp_v) begin
      failures++; $display("FAIL nfh_mr_latch got=%h exp=%h", dut_vec, exp_v);
    end
  endtask

  task automatic test_busy_hold();
    logic [63:0] a_vec;
    a_vec = pack(1, 2'b11, 4'd8, 0, 16'h7001, 16'h7002, 16'h7003, 8'h77);
    drive_id(1, 4'd1, 4'd1, 4'd8, 2'b11, 0, 8'h77, 16'h7001, 16'h7002, 16'h7003);
    exp_q.push_back(a_vec);
    step();
    exp_v = exp_q.pop_front();
    checks++;
    if (dut_vec !== exp_v) begin
      failures++; $display("FAIL busy_pre got=%h exp=%h", dut_vec, exp_v);
    end
    for (int k = 0; k < 3; k++) begin
      bus.ex_busy = 1'b1;
      drive_id(1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
               4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               8'($urandom_range(0, 255)), 16'($urandom_range(0, 65535)),
               16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));
      #1;
      checks++;
      if (bus.stall !== 1'b1) begin
        failures++; $display("FAIL busy_stall k=%0d got=%b exp=1", k, bus.stall);
      end
      exp_q.push_back(a_vec);
      exp_cnt++;
      step();
      exp_v = exp_q.pop_front();
      checks++;
      if (dut_vec !== exp_v) begin
        failures++; $display("FAIL busy_hold k=%0d got=%h exp=%h", k, dut_vec, exp_v);
      end
    end
    bus.ex_busy = 1'b0;
    drive_id(1, 4'd3, 4'd4, 4'd6, 2'b10, 0, 8'h78, 16'h8001, 16'h8002, 16'h8003);
    #1;
    checks++;
    if (bus.stall !== 1'b0) begin
      failures++; $display("FAIL busy_release got=%b exp=0", bus.stall);
    end
    exp_q.push_back(pack(1, 2'b10, 4'd6, 0, 16'h8001, 16'h8002, 16'h8003, 8'h78));
    step();
    exp_v = exp_q.pop_front();
    checks++;
    if (dut_vec !== exp_v) begin
      failures++; $display("FAIL busy_resume got=%h exp=%h", dut_vec, exp_v);
    end
    checks++;
    if (bus.stall_count !== 16'(exp_cnt)) begin
      failures++; $display("FAIL busy_count got=%h exp=%h", bus.stall_count, 16'(exp_cnt));
    end
  endtask

  task automatic test_flush();
    drive_id(1, 4'd0, 4'd0, 4'd2, 2'b01, 1, 8'h88, 16'h0A01, 16'h0A02, 16'h0A03);
    exp_q.push_back(pack(1, 2'b01, 4'd2, 1, 16'h0A01, 16'h0A02, 16'h0A03, 8'h88));
    step();
    exp_v = exp_q.pop_front();
    checks++;
    if (dut_vec !== exp_v) begin
      failures++; $display("FAIL flush_pre got=%h exp=%h", dut_vec, exp_v);
    end
    drive_id(1, 4'd2, 4'd0, 4'd4, 2'b01, 0, 8'h99, 16'h0B01, 16'h0B02, 16'h0B03);
    bus.flush = 1'b1;
    #1;
    checks++;
    if (bus.stall !== 1'b0) begin
      failures++; $display("FAIL flush_lu_stall got=%b exp=0", bus.stall);
    end
    exp_q.push_back(64'd0);
    step();
    exp_v = exp_q.pop_front();
    checks++;
    if (dut_vec !== exp_v) begin
      failures++; $display("FAIL flush_lu_bubble got=%h exp=%h", dut_vec, exp_v);
    end
    bus.flush = 1'b0;
    drive_id(1, 4'd1, 4'd2, 4'd3, 2'b01, 0, 8'hC0, 16'h0C01, 16'h0C02, 16'h0C03);
    exp_q.push_back(pack(1, 2'b01, 4'd3, 0, 16'h0C01, 16'h0C02, 16'h0C03, 8'hC0));
    step();
    exp_v = exp_q.pop_front();
    checks++;
    if (dut_vec !== exp_v) begin
      failures++; $display("FAIL flush_mid got=%h exp=%h", dut_vec, exp_v);
    end
    drive_id(1, 4'd5, 4'd6, 4'd7, 2'b11, 0, 8'hD0, 16'h0D01, 16'h0D02, 16'h0D03);
    bus.flush = 1'b1; bus.ex_busy = 1'b1;
    #1;
    checks++;
    if (bus.stall !== 1'b0) begin
      failures++; $display("FAIL flush_busy_stall got=%b exp=0", bus.stall);
    end
    exp_q.push_back(64'd0);
    step();
    exp_v = exp_q.pop_front();
    checks++;
    if (dut_vec !== exp_v) begin
      failures++; $display("FAIL flush_busy_bubble got=%h exp=%h", dut_vec, exp_v);
    end
    bus.flush = 1'b0; bus.ex_busy = 1'b0;
    drive_id(0, 4'd1, 4'd1, 4'd9, 2'b11, 1, 8'hE0, 16'h0E01, 16'h0E02, 16'h0E03);
    exp_q.push_back(64'd0);
    step();
    exp_v = exp_q.pop_front();
    checks++;
    if (dut_vec !== exp_v) begin
      failures++; $display("FAIL invalid_bubble got=%h exp=%h", dut_vec, exp_v);
    end
    checks++;
    if (bus.stall_count !== 16'(exp_cnt)) begin
      failures++; $display("FAIL flush_count got=%h exp=%h", bus.stall_count, 16'(exp_cnt));
    end
  endtask

  task automatic test_saturation_reset();
    drive_id(1, 4'd1, 4'd2, 4'd4, 2'b01, 0, 8'hF1, 16'h0F01, 16'h0F02, 16'h0F03);
    exp_q.push_back(pack(1, 2'b01, 4'd4, 0, 16'h0F01, 16'h0F02, 16'h0F03, 8'hF1));
    step();
    exp_v = exp_q.pop_front();
    checks++;
    if (dut_vec !== exp_v) begin
      failures++; $display("FAIL sat_pre got=%h exp=%h", dut_vec, exp_v);
    end
    bus.ex_busy = 1'b1;
    repeat (32'hFFFE - exp_cnt) @(posedge clk);
    #1;
    exp_cnt = 32'hFFFE;
    checks++;
    if (bus.stall_count !== 16'hFFFE) begin
      failures++; $display("FAIL sat_preload got=%h exp=fffe", bus.stall_count);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      exp_cnt = (exp_cnt >= 32'hFFFF) ? 32'hFFFF : exp_cnt + 1;
      checks++;
      if (bus.stall_count !== 16'(exp_cnt)) begin
        failures++; $display("FAIL sat_count k=%0d got=%h exp=%h", k, bus.stall_count, 16'(exp_cnt));
      end
    end
    exp_q.push_back(pack(1, 2'b01, 4'd4, 0, 16'h0F01, 16'h0F02, 16'h0F03, 8'hF1));
    exp_v = exp_q.pop_front();
    checks++;
    if (dut_vec !== exp_v) begin
      failures++; $display("FAIL sat_frozen got=%h exp=%h", dut_vec, exp_v);
    end
    rst = 1'b1;
    step();
    checks++;
    if (dut_vec !== 64'd0) begin
      failures++; $display("FAIL rst_hold_regs got=%h exp=%h", dut_vec, 64'd0);
    end
    checks++;
    if (bus.stall_count !== 16'd0) begin
      failures++; $display("FAIL rst_hold_count got=%h exp=0000", bus.stall_count);
    end
    rst = 1'b0;
    bus.ex_busy = 1'b0;
    exp_cnt = 0;
    drive_id(1, 4'd7, 4'd8, 4'd1, 2'b10, 0, 8'h5A, 16'h1001, 16'h1002, 16'h1003);
    #1;
    checks++;
    if (bus.stall !== 1'b0) begin
      failures++; $display("FAIL rst_stall got=%b exp=0", bus.stall);
    end
    exp_q.push_back(pack(1, 2'b10, 4'd1, 0, 16'h1001, 16'h1002, 16'h1003, 8'h5A));
    step();
    exp_v = exp_q.pop_front();
    checks++;
    if (dut_vec !== exp_v) begin
      failures++; $display("FAIL rst_resume got=%h exp=%h", dut_vec, exp_v);
    end
  endtask

  initial begin
    test_reset();
    test_fwd_mux();
    test_load_use();
    test_no_false_hazard();
    test_busy_hold();
    test_flush();
    test_saturation_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
